// File: rtl/ccu_pkg.sv
// Shared types for the CCU address scheduler: FSM states, grant record and
// the port-index width helper.
package ccu_pkg;

  // Widest port index the grant record can carry.
  localparam int unsigned CcuMaxIdxW = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_AW = 2'd1,
    GRANT_AR = 2'd2
  } ccu_sched_state_e;

  typedef struct packed {
    logic [CcuMaxIdxW-1:0] port;
    logic                  write;
  } ccu_grant_t;

  function automatic int unsigned ccu_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccu_rr_pick.sv
// Combinational round-robin picker: returns the first set request strictly
// after the pointer, wrapping, so the pointer's own slot has lowest priority.
module ccu_rr_pick
  import ccu_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = ccu_idx_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] w_cand;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = IdxW'((32'(ptr_i) + k) % N);
      if (!valid_o && req_i[w_cand]) begin
        idx_o   = w_cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccu_ax_scheduler.sv
// Serialises AW/AR requests from the core ports toward ccu_dispatch: one
// grant at a time, round-robin over ports, read/write alternation per port.
module ccu_ax_scheduler
  import ccu_pkg::*;
#(
  parameter  int unsigned NoPorts        = 2,
  parameter  int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW           = ccu_idx_w(NoPorts),
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NoPorts-1:0] core_aw_valid_i,
  output logic [NoPorts-1:0] core_aw_ready_o,
  input  logic [NoPorts-1:0] core_ar_valid_i,
  output logic [NoPorts-1:0] core_ar_ready_o,
  output logic [NoPorts-1:0] disp_aw_valid_o,
  input  logic [NoPorts-1:0] disp_aw_ready_i,
  output logic [NoPorts-1:0] disp_ar_valid_o,
  input  logic [NoPorts-1:0] disp_ar_ready_i,
  input  logic [NoPorts-1:0] b_done_i,
  input  logic [NoPorts-1:0] r_last_done_i,
  output logic               busy_o,
  output logic [IdxW-1:0]    grant_port_o,
  output logic               grant_write_o
);

  ccu_sched_state_e r_state, w_state_next;
  ccu_grant_t       r_grant;
  logic [IdxW-1:0]  r_rr_ptr;
  logic [NoPorts-1:0] r_last_was_wr;

  logic [NoPorts-1:0] w_aw_elig, w_ar_elig, w_elig;
  logic [IdxW-1:0]    w_pick_idx, w_gport;
  logic               w_pick_valid, w_pick_aw;
  logic               w_aw_hs, w_ar_hs;

  assign w_gport = r_grant.port[IdxW-1:0];
  assign w_elig  = w_aw_elig | w_ar_elig;

  ccu_rr_pick #(
    .N    (NoPorts),
    .IdxW (IdxW)
  ) u_pick (
    .req_i   (w_elig),
    .ptr_i   (r_rr_ptr),
    .idx_o   (w_pick_idx),
    .valid_o (w_pick_valid)
  );

  // AW unless AR is also eligible and this port's last grant was a write.
  assign w_pick_aw = w_aw_elig[w_pick_idx] &
                     (~w_ar_elig[w_pick_idx] | ~r_last_was_wr[w_pick_idx]);

  assign w_aw_hs = (r_state == GRANT_AW) && core_aw_valid_i[w_gport] && disp_aw_ready_i[w_gport];
  assign w_ar_hs = (r_state == GRANT_AR) && core_ar_valid_i[w_gport] && disp_ar_ready_i[w_gport];

  always_comb begin
    w_state_next    = r_state;
    disp_aw_valid_o = '0;
    disp_ar_valid_o = '0;
    core_aw_ready_o = '0;
    core_ar_ready_o = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) w_state_next = w_pick_aw ? GRANT_AW : GRANT_AR;
      end
      GRANT_AW: begin
        disp_aw_valid_o[w_gport] = core_aw_valid_i[w_gport];
        core_aw_ready_o[w_gport] = disp_aw_ready_i[w_gport];
        if (!core_aw_valid_i[w_gport] || disp_aw_ready_i[w_gport]) w_state_next = IDLE;
      end
      GRANT_AR: begin
        disp_ar_valid_o[w_gport] = core_ar_valid_i[w_gport];
        core_ar_ready_o[w_gport] = disp_ar_ready_i[w_gport];
        if (!core_ar_valid_i[w_gport] || disp_ar_ready_i[w_gport]) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (!rst_ni) begin
      disp_aw_valid_o = '0;
      disp_ar_valid_o = '0;
      core_aw_ready_o = '0;
      core_ar_ready_o = '0;
    end
  end

  assign busy_o        = rst_ni && (r_state != IDLE);
  assign grant_port_o  = rst_ni ? w_gport : '0;
  assign grant_write_o = rst_ni && r_grant.write;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= IdxW'(NoPorts - 1);
      r_last_was_wr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_pick_valid) begin
        r_grant.port  <= CcuMaxIdxW'(w_pick_idx);
        r_grant.write <= w_pick_aw;
      end
      if (w_aw_hs || w_ar_hs) begin
        r_rr_ptr               <= w_gport;
        r_last_was_wr[w_gport] <= w_aw_hs;
      end
    end
  end

  for (genvar gi = 0; gi < NoPorts; gi++) begin : g_port
    logic [CntW-1:0] r_wr_cnt, r_rd_cnt, w_wr_next, w_rd_next;
    logic            w_aw_inc, w_ar_inc;

    assign w_aw_inc = w_aw_hs && (w_gport == IdxW'(gi));
    assign w_ar_inc = w_ar_hs && (w_gport == IdxW'(gi));

    // A full counter blocks only its own channel.
    assign w_aw_elig[gi] = core_aw_valid_i[gi] && (r_wr_cnt < CntW'(MaxOutstanding));
    assign w_ar_elig[gi] = core_ar_valid_i[gi] && (r_rd_cnt < CntW'(MaxOutstanding));

    always_comb begin
      w_wr_next = r_wr_cnt;
      w_rd_next = r_rd_cnt;
      if (w_aw_inc && !b_done_i[gi]) w_wr_next = r_wr_cnt + CntW'(1);
      else if (!w_aw_inc && b_done_i[gi] && r_wr_cnt != '0) w_wr_next = r_wr_cnt - CntW'(1);
      if (w_ar_inc && !r_last_done_i[gi]) w_rd_next = r_rd_cnt + CntW'(1);
      else if (!w_ar_inc && r_last_done_i[gi] && r_rd_cnt != '0) w_rd_next = r_rd_cnt - CntW'(1);
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
      end else begin
        r_wr_cnt <= w_wr_next;
        r_rd_cnt <= w_rd_next;
      end
    end

    a_wr_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_wr_cnt <= CntW'(MaxOutstanding));
    a_rd_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      r_rd_cnt <= CntW'(MaxOutstanding));
    a_wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(b_done_i[gi] && !w_aw_inc && r_wr_cnt == '0));
    a_rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(r_last_done_i[gi] && !w_ar_inc && r_rd_cnt == '0));
  end

  a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({disp_aw_valid_o, disp_ar_valid_o}));
  a_port_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_grant.port < CcuMaxIdxW'(NoPorts));
  a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == GRANT_AW) |-> core_aw_valid_i[w_gport]);
  a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == GRANT_AR) |-> core_ar_valid_i[w_gport]);

endmodule

// File: tb/tb_ccu_ax_scheduler.sv
// Directed bench for ccu_ax_scheduler: expected grants are queued by the
// stimulus, and a negedge monitor scores every dispatch handshake.
module tb_ccu_ax_scheduler;

  localparam int unsigned NP   = 2;
  localparam int unsigned MAXO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] aw_v, ar_v, aw_rdy, ar_rdy, b_done, r_done;
  logic [NP-1:0] core_aw_ready, core_ar_ready, disp_aw_valid, disp_ar_valid;
  logic          busy;
  logic [0:0]    gport;
  logic          gwrite;
  logic          auto_resp = 1'b0;

  typedef struct packed {
    logic [0:0] port;
    logic       wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ccu_ax_scheduler #(
    .NoPorts        (NP),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .core_aw_valid_i (aw_v),
    .core_aw_ready_o (core_aw_ready),
    .core_ar_valid_i (ar_v),
    .core_ar_ready_o (core_ar_ready),
    .disp_aw_valid_o (disp_aw_valid),
    .disp_aw_ready_i (aw_rdy),
    .disp_ar_valid_o (disp_ar_valid),
    .disp_ar_ready_i (ar_rdy),
    .b_done_i        (b_done),
    .r_last_done_i   (r_done),
    .busy_o          (busy),
    .grant_port_o    (gport),
    .grant_write_o   (gwrite)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic push_exp(input int p, input logic wr);
    exp_t e;
    e.port = 1'(p);
    e.wr   = wr;
    exp_q.push_back(e);
  endtask

  task automatic score(input int p, input logic wr);
    exp_t e;
    $display("txn t=%0t port=%0d %s", $time, p, wr ? "AW" : "AR");
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_handshake: got port=%0d wr=%0b, required none", p, wr);
    end else begin
      e = exp_q.pop_front();
      chk("hs_port", 32'(p), 32'(e.port));
      chk("hs_write", 32'(wr), 32'(e.wr));
    end
  endtask

  // Monitor: scores handshakes and checks single-grant exclusivity.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("onehot_disp", 32'($onehot0({disp_aw_valid, disp_ar_valid})), 32'd1);
      for (int p = 0; p < NP; p++) begin
        if (disp_aw_valid[p] && aw_rdy[p]) score(p, 1'b1);
        if (disp_ar_valid[p] && ar_rdy[p]) score(p, 1'b0);
      end
    end
  end

  // Responder: returns one B / R-last the cycle after each handshake.
  initial begin
    logic [NP-1:0] hw, hr;
    forever begin
      @(negedge clk);
      hw = disp_aw_valid & aw_rdy;
      hr = disp_ar_valid & ar_rdy;
      @(posedge clk);
      #1;
      if (auto_resp) begin
        b_done = hw;
        r_done = hr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    auto_resp = 1'b0;
    rst_n     = 1'b0;
    aw_v      = '0;
    ar_v      = '0;
    b_done    = '0;
    r_done    = '0;
    step();
    step();
    b_done = '0;
    r_done = '0;
    rst_n  = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    aw_v   = '1;
    ar_v   = '1;
    aw_rdy = '1;
    ar_rdy = '1;
    b_done = '0;
    r_done = '0;

    // Reset with every valid high, then first-grant latency.
    push_exp(0, 1'b1);
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_disp_aw", 32'(disp_aw_valid), 32'd0);
    chk("rst_disp_ar", 32'(disp_ar_valid), 32'd0);
    chk("rst_core_aw_rdy", 32'(core_aw_ready), 32'd0);
    chk("rst_core_ar_rdy", 32'(core_ar_ready), 32'd0);
    step();
    chk("rst_busy2", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_no_fwd", 32'(disp_aw_valid | disp_ar_valid), 32'd0);
    step();
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_port", 32'(gport), 32'd0);
    chk("lat_write", 32'(gwrite), 32'd1);
    chk("lat_disp_aw", 32'(disp_aw_valid), 32'd1);
    chk("lat_core_aw_rdy", 32'(core_aw_ready), 32'd1);
    aw_v = 2'b01;
    ar_v = 2'b00;
    step();
    chk("lat_post_hs_idle", 32'(busy), 32'd0);
    aw_v = '0;

    // Fairness: both ports request AR.
    do_reset();
    auto_resp = 1'b1;
    ar_v      = 2'b11;
    for (int i = 0; i < 4; i++) push_exp(i % 2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fair_grant", 32'(disp_ar_valid), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("fair_port", 32'(gport), 32'(i % 2));
      step();
      chk("fair_bubble", 32'(disp_ar_valid | disp_aw_valid), 32'd0);
    end
    ar_v = '0;

    // Read/write alternation on port 0.
    do_reset();
    auto_resp = 1'b1;
    aw_v      = 2'b01;
    ar_v      = 2'b01;
    for (int i = 0; i < 4; i++) push_exp(0, (i % 2 == 0));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("alt_write", 32'(gwrite), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_busy", 32'(busy), 32'd1);
      step();
    end
    aw_v = '0;
    ar_v = '0;

    // Backpressure on port 1 AW while port 0 AR waits.
    do_reset();
    auto_resp = 1'b1;
    aw_rdy    = 2'b01;
    aw_v      = 2'b10;
    push_exp(1, 1'b1);
    push_exp(0, 1'b0);
    step();
    ar_v = 2'b01;
    for (int i = 0; i < 5; i++) begin
      chk("bp_port", 32'(gport), 32'd1);
      chk("bp_disp_aw", 32'(disp_aw_valid), 32'd2);
      chk("bp_ar_stalled", 32'(disp_ar_valid | core_ar_ready), 32'd0);
      step();
    end
    aw_rdy = 2'b11;
    chk("bp_hs_cycle_valid", 32'(disp_aw_valid), 32'd2);
    step();
    aw_v = '0;
    chk("bp_bubble", 32'(busy), 32'd0);
    step();
    chk("bp_next_port", 32'(gport), 32'd0);
    chk("bp_next_write", 32'(gwrite), 32'd0);
    chk("bp_next_disp_ar", 32'(disp_ar_valid), 32'd1);
    step();
    ar_v = '0;

    // Outstanding cap: four AW with no B, then AR still passes.
    do_reset();
    aw_rdy = '1;
    ar_rdy = '1;
    aw_v   = 2'b01;
    for (int i = 0; i < 4; i++) push_exp(0, 1'b1);
    repeat (8) step();
    repeat (6) begin
      step();
      chk("cap_blocked", 32'(busy), 32'd0);
    end
    ar_v = 2'b01;
    push_exp(0, 1'b0);
    step();
    chk("cap_ar_grant", 32'(disp_ar_valid), 32'd1);
    step();
    ar_v = '0;
    step();
    chk("cap_still_blocked", 32'(busy), 32'd0);
    b_done = 2'b01;
    step();
    b_done = '0;
    chk("cap_release_idle", 32'(busy), 32'd0);
    push_exp(0, 1'b1);
    step();
    chk("cap_5th_grant", 32'(disp_aw_valid), 32'd1);
    step();

    // Issue and completion in the same cycle leave the count unchanged.
    step();
    chk("same_blocked", 32'(busy), 32'd0);
    b_done = 2'b01;
    step();
    b_done = '0;
    push_exp(0, 1'b1);
    step();
    chk("same_grant", 32'(disp_aw_valid), 32'd1);
    b_done = 2'b01;
    step();
    b_done = '0;
    push_exp(0, 1'b1);
    step();
    chk("same_one_more", 32'(disp_aw_valid), 32'd1);
    step();
    repeat (4) begin
      step();
      chk("same_capped", 32'(busy), 32'd0);
    end
    aw_v = '0;

    // Reset while an AR grant is stalled.
    ar_rdy = 2'b00;
    ar_v   = 2'b01;
    step();
    chk("mid_grant_busy", 32'(busy), 32'd1);
    chk("mid_grant_write", 32'(gwrite), 32'd0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_disp_ar", 32'(disp_ar_valid), 32'd0);
    ar_v   = '0;
    ar_rdy = '1;
    rst_n  = 1'b1;
    #1;
    chk("mid_rel_idle", 32'(busy), 32'd0);
    aw_v = 2'b01;
    for (int i = 0; i < 4; i++) push_exp(0, 1'b1);
    repeat (8) step();
    repeat (3) begin
      step();
      chk("mid_cnt_cleared_cap", 32'(busy), 32'd0);
    end
    aw_v = '0;
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
